rgb565_pack: RTL and testbench

//  Packs a byte-serial RGB888 pixel stream (3 bytes/pixel) into 16-bit RGB565 words.

---
 rtl/rgb565_pkg.sv | 17 +
 rtl/rgb565_chan_quant.sv | 34 +++
 rtl/rgb565_pack.sv | 119 +++++++++++
 tb/tb_rgb565_pack.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_pkg.sv
// Shared types for the RGB888 -> RGB565 byte-stream packer.
// Optional feature macro: RGB565_ROUND_EN (see rgb565_chan_quant).
package rgb565_pkg;

    localparam int unsigned R_BITS = 5;
    localparam int unsigned G_BITS = 6;
    localparam int unsigned B_BITS = 5;

    typedef enum logic [1:0] {PH0, PH1, PH2} rgb565_phase_t;

    typedef struct packed {
        logic [R_BITS-1:0] r;
        logic [G_BITS-1:0] g;
        logic [B_BITS-1:0] b;
    } rgb565_t;

endpackage

// File: rtl/rgb565_chan_quant.sv
// Single colour-channel quantiser, IN_BITS -> OUT_BITS, purely combinational.
// Macro RGB565_ROUND_EN: round-half-up with saturation at the all-ones code.
// Without it the channel is truncated to its top OUT_BITS bits.
module rgb565_chan_quant
    import rgb565_pkg::*;
#(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = R_BITS
) (
    input  logic [IN_BITS-1:0]  din,
    output logic [OUT_BITS-1:0] dout
);

    // Bits below the kept (or rounding) position are deliberately discarded.
    logic unused_din;

`ifdef RGB565_ROUND_EN
    logic [OUT_BITS:0] sum;

    // One-bit-wider add of the first dropped bit, then clamp on carry-out.
    always_comb begin
        sum        = {1'b0, din[IN_BITS-1 -: OUT_BITS]} + (OUT_BITS+1)'(din[IN_BITS-OUT_BITS-1]);
        dout       = sum[OUT_BITS] ? '1 : sum[OUT_BITS-1:0];
        unused_din = ^din;
    end
`else
    // Plain truncation: keep the most significant OUT_BITS bits.
    always_comb begin
        dout       = din[IN_BITS-1 -: OUT_BITS];
        unused_din = ^din;
    end
`endif

endmodule

// File: rtl/rgb565_pack.sv
// Byte-serial RGB888 (3 bytes/pixel) to 16-bit RGB565 packer with valid/ready
// on both sides and a single registered output word held under backpressure.
// Optional feature macro: RGB565_ROUND_EN (rounding quantisers instead of truncation).
module rgb565_pack
    import rgb565_pkg::*;
#(
    parameter int unsigned IN_ORDER_RGB = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic        frame_start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        sync_err
);

    rgb565_phase_t     state_q, state_d;
    logic [7:0]        held0_q, held0_d;
    logic [7:0]        held1_q, held1_d;
    rgb565_t           out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;

    logic              accept;
    logic [7:0]        r_byte, b_byte;
    logic [R_BITS-1:0] r_q5;
    logic [G_BITS-1:0] g_q6;
    logic [B_BITS-1:0] b_q5;
    rgb565_t           packed_px;

    // Phase 0 carries R or B depending on byte order; phase 2 carries the other.
    always_comb begin
        if (IN_ORDER_RGB != 0) begin
            r_byte = held0_q;
            b_byte = in_byte;
        end else begin
            r_byte = in_byte;
            b_byte = held0_q;
        end
    end

    rgb565_chan_quant #(.IN_BITS(8), .OUT_BITS(R_BITS)) u_quant_r (.din(r_byte),  .dout(r_q5));
    rgb565_chan_quant #(.IN_BITS(8), .OUT_BITS(G_BITS)) u_quant_g (.din(held1_q), .dout(g_q6));
    rgb565_chan_quant #(.IN_BITS(8), .OUT_BITS(B_BITS)) u_quant_b (.din(b_byte),  .dout(b_q5));

    // Only the final phase can stall; the output slot frees up in the same cycle it drains.
    always_comb begin
        in_ready = (state_q != PH2) || !out_valid_q || out_ready;
    end

    // Next-state: phase advance, channel holding, output slot and sticky sync error.
    always_comb begin
        accept      = in_valid && in_ready;
        packed_px   = '{r: r_q5, g: g_q6, b: b_q5};
        state_d     = state_q;
        held0_d     = held0_q;
        held1_d     = held1_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        sync_err_d  = sync_err_q;
        if (accept) begin
            if (frame_start) begin
                // Resynchronise: this byte is phase 0, any partial pixel is dropped.
                held0_d = in_byte;
                state_d = PH1;
                if (state_q != PH0) begin
                    sync_err_d = 1'b1;
                end
            end else begin
                case (state_q)
                    PH0: begin
                        held0_d = in_byte;
                        state_d = PH1;
                    end
                    PH1: begin
                        held1_d = in_byte;
                        state_d = PH2;
                    end
                    PH2: begin
                        out_data_d  = packed_px;
                        out_valid_d = 1'b1;
                        state_d     = PH0;
                    end
                    default: state_d = PH0;
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PH0;
            held0_q     <= '0;
            held1_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            held0_q     <= held0_d;
            held1_q     <= held1_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        out_data  = out_data_q;
        out_valid = out_valid_q;
        sync_err  = sync_err_q;
    end

endmodule

// File: tb/tb_rgb565_pack.sv
// Bench for rgb565_pack: one DUT in R,G,B byte order and one in B,G,R order
// share the same stimulus; a scoreboard per DUT holds the expected words.
module tb_rgb565_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        frame_start = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready_a, in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [15:0] out_data_a, out_data_b;
    logic        sync_err_a, sync_err_b;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_count = 0;
    int          m_held0 = 0;
    int          m_held1 = 0;
    logic        m_sync = 1'b0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    int          ready_mode = 0;   // 0: always ready, 1: never ready, 2: random

    rgb565_pack #(.IN_ORDER_RGB(1)) u_dut_rgb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_byte(in_byte), .frame_start(frame_start), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .sync_err(sync_err_a)
    );

    rgb565_pack #(.IN_ORDER_RGB(0)) u_dut_bgr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_byte(in_byte), .frame_start(frame_start), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .sync_err(sync_err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Quantise an 8-bit channel value to 'bits' bits using plain arithmetic.
    function automatic int q_chan(input int v, input int bits);
        int sh;
        int r;
        sh = 8 - bits;
`ifdef RGB565_ROUND_EN
        r = (v + (1 << (sh - 1))) >> sh;
        if (r > (1 << bits) - 1) r = (1 << bits) - 1;
`else
        r = v >> sh;
`endif
        return r;
    endfunction

    function automatic logic [15:0] pack_exp(input int r, input int g, input int b);
        int v;
        v = (q_chan(r, 5) << 11) | (q_chan(g, 6) << 5) | q_chan(b, 5);
        return v[15:0];
    endfunction

    // Model update for one accepted byte.
    task automatic model_accept(input int b, input logic fs);
        if (fs) begin
            if (m_count != 0) m_sync = 1'b1;
            m_held0 = b;
            m_count = 1;
        end else if (m_count == 0) begin
            m_held0 = b;
            m_count = 1;
        end else if (m_count == 1) begin
            m_held1 = b;
            m_count = 2;
        end else begin
            q_a.push_back(pack_exp(m_held0, m_held1, b));
            q_b.push_back(pack_exp(b, m_held1, m_held0));
            m_count = 0;
        end
    endtask

    // Drive one byte and wait (bounded) for it to be accepted.
    task automatic send(input logic [7:0] b, input logic fs, input logic expect_stall);
        int  waits;
        logic exp_ready;
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte = b;
        frame_start = fs;
        #3;
        if (expect_stall) begin
            chk("stall_in_ready", 32'(in_ready_a), 32'd0);
            ready_mode = 0;
        end
        forever begin
            exp_ready = (m_count < 2) || (q_a.size() == 0) || out_ready;
            chk("in_ready_a", 32'(in_ready_a), 32'(exp_ready));
            chk("in_ready_b", 32'(in_ready_b), 32'(exp_ready));
            if (in_ready_a) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            #3;
        end
        if (in_ready_a) model_accept(int'(b), fs);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    // One cycle without a valid byte; frame_start may toggle and must be ignored.
    task automatic idle_cycle(input logic fs_noise);
        @(negedge clk);
        in_valid = 1'b0;
        frame_start = fs_noise;
        in_byte = 8'($urandom);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic set_mode(input int m);
        ready_mode = m;
        if (m == 0) out_ready = 1'b1;
        if (m == 1) out_ready = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        frame_start = 1'b0;
        m_count = 0;
        m_sync = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #4;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        chk("rst_sync_err", 32'(sync_err_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'h0000);
        chk("rst_out_data_b", 32'(out_data_b), 32'h0000);
    endtask

    // Directed check of the word presented one cycle after the last byte.
    task automatic check_out(input string name, input logic [15:0] exp_a, input logic [15:0] exp_b);
        @(negedge clk);
        #4;
        chk({name, "_valid"}, 32'(out_valid_a), 32'd1);
        chk({name, "_data_rgb"}, 32'(out_data_a), 32'(exp_a));
        chk({name, "_data_bgr"}, 32'(out_data_b), 32'(exp_b));
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: compares presented words, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("mon_valid_rgb", 32'(out_valid_a), 32'(q_a.size() != 0));
                chk("mon_valid_bgr", 32'(out_valid_b), 32'(q_b.size() != 0));
                chk("mon_sync_rgb", 32'(sync_err_a), 32'(m_sync));
                chk("mon_sync_bgr", 32'(sync_err_b), 32'(m_sync));
                if (q_a.size() != 0) begin
                    chk("mon_data_rgb", 32'(out_data_a), 32'(q_a[0]));
                    chk("mon_data_bgr", 32'(out_data_b), 32'(q_b[0]));
                    if (out_ready) begin
                        void'(q_a.pop_front());
                        void'(q_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles
        reset_dut();

        // Single pixel, immediate drain, valid for exactly one cycle
        set_mode(0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        check_out("px_ff00ff", 16'hF81F, 16'hF81F);
        @(negedge clk);
        #4;
        chk("one_cycle_valid", 32'(out_valid_a), 32'd0);

        // Backpressure: first word held, sixth byte stalls, then drain in order
        set_mode(1);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b1);
        repeat (4) idle_cycle(1'b0);

        // Reset mid-operation drops the held word and a partial pixel
        set_mode(1);
        send(8'h10, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        send(8'h30, 1'b0, 1'b0);
        send(8'h40, 1'b0, 1'b0);
        reset_dut();
        set_mode(0);
        send(8'h01, 1'b0, 1'b0);
        send(8'h82, 1'b0, 1'b0);
        send(8'hF3, 1'b0, 1'b0);
        repeat (2) idle_cycle(1'b1);

        // frame_start mid-pixel resynchronises and sets the sticky error
        send(8'h12, 1'b0, 1'b0);
        send(8'h34, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        check_out("resync", 16'hFFFF, 16'hFFFF);
        chk("sync_err_set", 32'(sync_err_a), 32'd1);

        // Rounding / truncation corner
        send(8'h0C, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
`ifdef RGB565_ROUND_EN
        check_out("quant", 16'h103F, 16'hF822);
`else
        check_out("quant", 16'h081F, 16'hF801);
`endif

        // Byte-order parameter: FF,00,00
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check_out("order", 16'hF800, 16'h001F);
        chk("sync_err_sticky", 32'(sync_err_a), 32'd1);

        // Randomised traffic with random backpressure and occasional frame_start
        reset_dut();
        set_mode(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
            send(8'($urandom), ($urandom_range(0, 11) == 0), 1'b0);
        end
        set_mode(0);
        repeat (6) idle_cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
